// File: rtl/sram_pattern_tester.sv
// sram_pattern_tester
//   March-style self test for a byte-wide SRAM behind a single-op controller.
//   Four passes over addresses 0..ADDR_LAST:
//     P0 write addr[7:0], P1 read/compare, P2 write ~addr[7:0], P3 read/compare.
//   Mismatches are counted (saturating) and the first one is captured.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   test_start               pulse to start a test (accepted only when idle and controller idle)
//   test_busy / test_done    run in progress / 1-cycle end-of-test pulse
//   test_pass / test_timeout held results of the last test
//   err_count, first_err_*   mismatch count and first-failure capture
//   start_operation, rw, address_input, data_f2s
//                            command interface to the SRAM controller
//   data_s2f, data_ready_signal_output, writing_finished_signal_output, busy_signal_output
//                            response interface from the SRAM controller
module sram_pattern_tester #(
    parameter int                    ADDR_WIDTH = 19,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] ADDR_LAST  = 19'h7FFFF,
    parameter int                    TIMEOUT    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  test_start,
    output logic                  test_busy,
    output logic                  test_done,
    output logic                  test_pass,
    output logic                  test_timeout,
    output logic [15:0]           err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [DATA_WIDTH-1:0] first_err_exp,
    output logic [DATA_WIDTH-1:0] first_err_got,
    output logic                  start_operation,
    output logic                  rw,
    output logic [ADDR_WIDTH-1:0] address_input,
    output logic [DATA_WIDTH-1:0] data_f2s,
    input  logic [DATA_WIDTH-1:0] data_s2f,
    input  logic                  data_ready_signal_output,
    input  logic                  writing_finished_signal_output,
    input  logic                  busy_signal_output
);

    localparam int                TIMER_W    = $clog2(TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [1:0]              phase_q;
    logic [TIMER_W-1:0]      timer_q;
    logic [DATA_WIDTH-1:0]   pattern;
    logic                    op_done;
    logic                    last_op;
    logic                    mismatch;
    logic                    accept;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // phase[0] selects read, phase[1] selects the inverted pattern
    assign pattern       = phase_q[1] ? ~addr_q[DATA_WIDTH-1:0] : addr_q[DATA_WIDTH-1:0];
    assign rw            = phase_q[0];
    assign address_input = addr_q;
    assign data_f2s      = pattern;

    // Only the completion pulse matching the current direction counts
    assign op_done  = phase_q[0] ? data_ready_signal_output : writing_finished_signal_output;
    assign last_op  = (addr_q == ADDR_LAST) && (phase_q == 2'd3);
    assign mismatch = phase_q[0] && data_ready_signal_output && (data_s2f != pattern);
    assign accept   = test_start && !busy_signal_output;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        start_operation = 1'b0;
        test_busy       = 1'b0;
        test_done       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) state_d = ISSUE;
            end
            ISSUE: begin
                test_busy = 1'b1;
                // Never strobe into a busy controller; normally it is idle here
                if (!busy_signal_output) begin
                    start_operation = 1'b1;
                    state_d         = WAIT;
                end
            end
            WAIT: begin
                test_busy = 1'b1;
                if (op_done)                    state_d = last_op ? FIN : ISSUE;
                else if (timer_q == TIMER_LAST) state_d = FIN;
            end
            FIN: begin
                test_busy = 1'b1;
                test_done = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q         <= '0;
            phase_q        <= '0;
            timer_q        <= '0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_exp  <= '0;
            first_err_got  <= '0;
            test_pass      <= 1'b0;
            test_timeout   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        addr_q         <= '0;
                        phase_q        <= '0;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        first_err_exp  <= '0;
                        first_err_got  <= '0;
                        test_pass      <= 1'b0;
                        test_timeout   <= 1'b0;
                    end
                end
                ISSUE: begin
                    timer_q <= '0;
                end
                WAIT: begin
                    timer_q <= timer_q + TIMER_W'(1);
                    if (op_done) begin
                        if (mismatch) begin
                            err_count <= sat_inc(err_count);
                            // Count never returns to zero, so zero means no error yet
                            if (err_count == 16'd0) begin
                                first_err_addr <= addr_q;
                                first_err_exp  <= pattern;
                                first_err_got  <= data_s2f;
                            end
                        end
                        // The final op leaves addr/phase in place so the command bus holds
                        if (!last_op) begin
                            if (addr_q == ADDR_LAST) begin
                                addr_q  <= '0;
                                phase_q <= phase_q + 2'd1;
                            end else begin
                                addr_q  <= addr_q + ADDR_WIDTH'(1);
                            end
                        end
                    end else if (timer_q == TIMER_LAST) begin
                        test_timeout <= 1'b1;
                    end
                end
                FIN: begin
                    test_pass <= (err_count == 16'd0) && !test_timeout;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_pattern_tester.sv
// Testbench for sram_pattern_tester: behavioural SRAM controller + 16-byte memory
// with selectable faults, table-driven full runs and hand-written corner sequences.
module tb_sram_pattern_tester;

    localparam int AW = 19;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ctl_rst = 1'b1;
    logic          test_start = 1'b0;
    logic          test_busy, test_done, test_pass, test_timeout;
    logic [15:0]   err_count;
    logic [AW-1:0] first_err_addr;
    logic [DW-1:0] first_err_exp, first_err_got;
    logic          start_operation, rw;
    logic [AW-1:0] address_input;
    logic [DW-1:0] data_f2s;

    // controller model state
    logic          c_busy = 1'b0;
    logic          c_wr_done = 1'b0;
    logic          c_rd_done = 1'b0;
    logic [DW-1:0] c_rdata = '0;
    logic [1:0]    c_cnt = '0;
    logic          c_rw = 1'b0;
    logic [AW-1:0] c_addr = '0;
    logic [DW-1:0] c_wdata = '0;
    logic [DW-1:0] mem [0:15];
    int            wr_seen = 0;
    // 0 none, 1 bit3 stuck-1 at addr 5, 2 addr 9 aliased to 1,
    // 3 drop 3rd write completion, 4 both completion pulses on every op
    int            fault_mode = 0;

    // monitor state
    int            cyc = 0;
    int            ops = 0;
    int            done_cnt = 0;
    int            last_so_cyc = 0;
    int            mon_viol = 0;
    logic          prev_so = 1'b0;

    int            checks = 0;
    int            errors = 0;

    sram_pattern_tester #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .ADDR_LAST (19'd15),
        .TIMEOUT   (32)
    ) dut (
        .clk                           (clk),
        .rst                           (rst),
        .test_start                    (test_start),
        .test_busy                     (test_busy),
        .test_done                     (test_done),
        .test_pass                     (test_pass),
        .test_timeout                  (test_timeout),
        .err_count                     (err_count),
        .first_err_addr                (first_err_addr),
        .first_err_exp                 (first_err_exp),
        .first_err_got                 (first_err_got),
        .start_operation               (start_operation),
        .rw                            (rw),
        .address_input                 (address_input),
        .data_f2s                      (data_f2s),
        .data_s2f                      (c_rdata),
        .data_ready_signal_output      (c_rd_done),
        .writing_finished_signal_output(c_wr_done),
        .busy_signal_output            (c_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] map_addr(input logic [AW-1:0] a, input int mode);
        if (mode == 2 && a == 19'd9) return 4'd1;
        return a[3:0];
    endfunction

    // Controller: busy for 4 cycles after a strobe, completion pulse in the 4th
    always @(posedge clk) begin
        if (ctl_rst) begin
            c_busy    <= 1'b0;
            c_cnt     <= '0;
            c_wr_done <= 1'b0;
            c_rd_done <= 1'b0;
            wr_seen   <= 0;
        end else begin
            c_wr_done <= 1'b0;
            c_rd_done <= 1'b0;
            if (!c_busy) begin
                if (start_operation) begin
                    c_busy  <= 1'b1;
                    c_cnt   <= '0;
                    c_rw    <= rw;
                    c_addr  <= address_input;
                    c_wdata <= data_f2s;
                end
            end else begin
                c_cnt <= c_cnt + 2'd1;
                if (c_cnt == 2'd2) begin
                    if (c_rw) begin
                        if (fault_mode == 1 && c_addr == 19'd5)
                            c_rdata <= mem[map_addr(c_addr, fault_mode)] | 8'h08;
                        else
                            c_rdata <= mem[map_addr(c_addr, fault_mode)];
                        c_rd_done <= 1'b1;
                        if (fault_mode == 4) c_wr_done <= 1'b1;
                    end else begin
                        mem[map_addr(c_addr, fault_mode)] <= c_wdata;
                        wr_seen <= wr_seen + 1;
                        if (!(fault_mode == 3 && wr_seen == 2)) c_wr_done <= 1'b1;
                        if (fault_mode == 4) c_rd_done <= 1'b1;
                    end
                end
                if (c_cnt == 2'd3) c_busy <= 1'b0;
            end
        end
    end

    // Protocol monitor: strobe never into a busy controller, never two cycles long
    always @(posedge clk) begin
        if (start_operation) begin
            ops = ops + 1;
            last_so_cyc = cyc;
            if (c_busy || prev_so) mon_viol = mon_viol + 1;
        end
        if (test_done) done_cnt = done_cnt + 1;
        prev_so = start_operation;
        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic do_reset(input int mode);
        @(posedge clk); #1;
        rst = 1'b1; ctl_rst = 1'b1; test_start = 1'b0; fault_mode = mode;
        @(posedge clk); #1;
        rst = 1'b0; ctl_rst = 1'b0;
    endtask

    task automatic wait_done(input int limit, output logic ok, output int d);
        ok = 1'b0;
        d  = 0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(posedge clk); #1;
            if (test_done) begin ok = 1'b1; d = cyc; end
        end
    endtask

    task automatic wait_ops(input int target, input int limit, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < limit && !ok; i++) begin
            @(posedge clk); #1;
            if (ops >= target) ok = 1'b1;
        end
    endtask

    typedef struct packed {
        int            mode;
        logic          exp_pass;
        logic          exp_to;
        logic [15:0]   exp_err;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_e;
        logic [DW-1:0] exp_g;
        int            exp_ops;
        int            exp_tail;   // cycles from last strobe to test_done
    } vec_t;

    vec_t vecs [5];

    task automatic run_row(input vec_t v, input int r);
        int   base_ops, base_done, s, d;
        logic ok;
        do_reset(v.mode);
        base_ops  = ops;
        base_done = done_cnt;
        test_start = 1'b1;
        s = cyc;
        @(posedge clk); #1;
        test_start = 1'b0;
        check($sformatf("r%0d_busy", r), test_busy, 1);
        wait_done(400, ok, d);
        check($sformatf("r%0d_done_seen", r), ok, 1);
        check($sformatf("r%0d_latency_le_324", r), (d - s) <= 324, 1);
        check($sformatf("r%0d_ops", r), ops - base_ops, v.exp_ops);
        check($sformatf("r%0d_tail", r), d - last_so_cyc, v.exp_tail);
        @(posedge clk); #1;
        check($sformatf("r%0d_pass", r), test_pass, v.exp_pass);
        check($sformatf("r%0d_timeout", r), test_timeout, v.exp_to);
        check($sformatf("r%0d_err_count", r), err_count, v.exp_err);
        check($sformatf("r%0d_first_addr", r), first_err_addr, v.exp_addr);
        check($sformatf("r%0d_first_exp", r), first_err_exp, v.exp_e);
        check($sformatf("r%0d_first_got", r), first_err_got, v.exp_g);
        check($sformatf("r%0d_done_1cyc", r), test_done, 0);
        check($sformatf("r%0d_idle_after", r), test_busy, 0);
        repeat (6) @(posedge clk);
        #1;
        check($sformatf("r%0d_pass_hold", r), test_pass, v.exp_pass);
        check($sformatf("r%0d_done_once", r), done_cnt - base_done, 1);
    endtask

    initial begin
        int   base_ops, base_done, d;
        logic ok, gated;

        vecs[0] = '{0, 1'b1, 1'b0, 16'd0, 19'd0, 8'h00, 8'h00, 64, 5};
        vecs[1] = '{1, 1'b0, 1'b0, 16'd1, 19'd5, 8'h05, 8'h0D, 64, 5};
        vecs[2] = '{2, 1'b0, 1'b0, 16'd2, 19'd1, 8'h01, 8'h09, 64, 5};
        vecs[3] = '{3, 1'b0, 1'b1, 16'd0, 19'd0, 8'h00, 8'h00, 3, 33};
        vecs[4] = '{4, 1'b1, 1'b0, 16'd0, 19'd0, 8'h00, 8'h00, 64, 5};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", test_busy, 0);
        check("rst_done", test_done, 0);
        check("rst_pass", test_pass, 0);
        check("rst_timeout", test_timeout, 0);
        check("rst_err", err_count, 0);
        check("rst_start_op", start_operation, 0);
        check("rst_addr", address_input, 0);
        check("rst_rw", rw, 0);
        check("rst_wdata", data_f2s, 0);
        rst = 1'b0; ctl_rst = 1'b0;

        for (int r = 0; r < 5; r++) run_row(vecs[r], r);

        // Reset in the middle of P2 while the controller is busy
        do_reset(0);
        test_start = 1'b1;
        @(posedge clk); #1;
        test_start = 1'b0;
        base_ops = ops - 1;
        wait_ops(base_ops + 34, 400, ok);
        check("midrst_reach_p2", ok, 1);
        check("midrst_ctl_busy", c_busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_busy", test_busy, 0);
        check("midrst_start_op", start_operation, 0);
        check("midrst_err", err_count, 0);
        check("midrst_pass", test_pass, 0);
        check("midrst_addr", address_input, 0);
        check("midrst_rw", rw, 0);
        test_start = 1'b1;
        gated = 1'b1;
        for (int i = 0; i < 20 && c_busy; i++) begin
            if (test_busy) gated = 1'b0;
            @(posedge clk); #1;
        end
        check("midrst_gated", gated, 1);
        for (int i = 0; i < 5 && !test_busy; i++) begin
            @(posedge clk); #1;
        end
        check("midrst_restart", test_busy, 1);
        test_start = 1'b0;
        base_ops = ops;
        wait_done(400, ok, d);
        check("midrst_done", ok, 1);
        @(posedge clk); #1;
        check("midrst_ops", ops - base_ops, 64);
        check("midrst_final_pass", test_pass, 1);
        check("midrst_final_err", err_count, 0);

        // test_start during a run is ignored
        do_reset(0);
        base_ops  = ops;
        base_done = done_cnt;
        test_start = 1'b1;
        @(posedge clk); #1;
        test_start = 1'b0;
        wait_ops(base_ops + 10, 400, ok);
        test_start = 1'b1;
        @(posedge clk); #1;
        test_start = 1'b0;
        wait_ops(base_ops + 40, 400, ok);
        test_start = 1'b1;
        @(posedge clk); #1;
        test_start = 1'b0;
        wait_done(400, ok, d);
        check("restart_done", ok, 1);
        repeat (20) @(posedge clk);
        #1;
        check("restart_done_once", done_cnt - base_done, 1);
        check("restart_ops", ops - base_ops, 64);
        check("restart_pass", test_pass, 1);
        check("restart_err", err_count, 0);
        check("restart_idle", test_busy, 0);

        check("protocol_violations", mon_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
